// File: rtl/cb_dispatch.sv
// cb_dispatch: code-block dispatcher between the segmentation byte stream and
// NUM_LANES turbo-encoder input buffers.
//
// Each code block that starts on an in_start byte is assigned to one ready lane.
// The lane is chosen round-robin from rr_ptr. A byte counter marks the last byte
// of the block. Every accepted byte is written to the lanes one cycle later.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_start/in_size/in_data/in_crc/in_filling
//                       upstream byte and its flags
//   in_stall            combinational back-pressure; upstream holds its byte
//   cfg_k0_bytes/cfg_k1_bytes
//                       block lengths in bytes, selected by in_size on the start byte
//   lane_ready          per-lane "can take a whole block", looked at only at grant
//   lane_wr             one-hot registered write strobe
//   lane_data/lane_size/lane_start/lane_last/lane_crc/lane_filling
//                       shared registered write payload
//   lane_abort          one-cycle discard pulse for the lane holding a cut-short block
//   err_proto           sticky protocol error, cleared by reset only
//   blk_count           completed blocks, wraps at 65535

// Per-lane strobe register. It turns the combinational select into the
// registered lane_wr and lane_abort bits.
module cb_dispatch_lane (
  input  logic clk,
  input  logic reset,
  input  logic wr_sel,
  input  logic abort_sel,
  output logic wr,
  output logic abort
);
  always_ff @(posedge clk) begin
    if (reset) begin
      wr    <= 1'b0;
      abort <= 1'b0;
    end else begin
      wr    <= wr_sel;
      abort <= abort_sel;
    end
  end
endmodule

module cb_dispatch #(
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_start,
  input  logic                 in_size,
  input  logic [7:0]           in_data,
  input  logic                 in_crc,
  input  logic                 in_filling,
  output logic                 in_stall,
  input  logic [CNT_W-1:0]     cfg_k0_bytes,
  input  logic [CNT_W-1:0]     cfg_k1_bytes,
  input  logic [NUM_LANES-1:0] lane_ready,
  output logic [NUM_LANES-1:0] lane_wr,
  output logic [7:0]           lane_data,
  output logic                 lane_size,
  output logic                 lane_start,
  output logic                 lane_last,
  output logic                 lane_crc,
  output logic                 lane_filling,
  output logic [NUM_LANES-1:0] lane_abort,
  output logic                 err_proto,
  output logic [15:0]          blk_count
);
  localparam int PTR_W = $clog2(NUM_LANES);

  typedef enum logic {IDLE, XFER} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       size;
    logic       start;
    logic       last;
    logic       crc;
    logic       filling;
  } beat_t;

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant;
  logic [CNT_W-1:0]    count;
  logic                blk_size;
  beat_t               beat;

  logic                accept;
  logic                do_write;
  logic                do_abort;
  logic [PTR_W-1:0]    scan_idx;
  logic [PTR_W-1:0]    wr_lane;
  logic [CNT_W-1:0]    len_sel;
  logic                len_zero;
  logic                len_le1;
  logic [NUM_LANES-1:0] sel_wr;
  logic [NUM_LANES-1:0] sel_abort;

  // In IDLE a start byte waits only when no lane is ready. In XFER any start
  // byte waits: it is cut short here and granted again from IDLE.
  always_comb begin
    in_stall = in_valid && in_start && ((state == XFER) || (lane_ready == '0));
  end

  assign accept   = in_valid && !in_stall;
  assign do_write = accept && ((state == XFER) || in_start);
  assign do_abort = (state == XFER) && in_valid && in_start;

  assign len_sel  = in_size ? cfg_k1_bytes : cfg_k0_bytes;
  assign len_zero = (len_sel == '0);
  // A zero length is handled as a one-byte block.
  assign len_le1  = len_zero || (len_sel == CNT_W'(1));

  // Pick the first ready lane at or above rr_ptr, wrapping around.
  always_comb begin
    logic           hit;
    logic [PTR_W:0] idx;
    hit      = 1'b0;
    idx      = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_LANES)) idx = idx - (PTR_W+1)'(NUM_LANES);
      if (!hit && lane_ready[idx[PTR_W-1:0]]) begin
        hit      = 1'b1;
        scan_idx = idx[PTR_W-1:0];
      end
    end
  end

  assign wr_lane = (state == IDLE) ? scan_idx : grant;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sel
    assign sel_wr[i]    = do_write && (wr_lane == PTR_W'(i));
    assign sel_abort[i] = do_abort && (grant == PTR_W'(i));
  end

  cb_dispatch_lane u_lane [NUM_LANES-1:0] (
    .clk       (clk),
    .reset     (reset),
    .wr_sel    (sel_wr),
    .abort_sel (sel_abort),
    .wr        (lane_wr),
    .abort     (lane_abort)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      count     <= '0;
      blk_size  <= 1'b0;
      beat      <= '0;
      err_proto <= 1'b0;
      blk_count <= '0;
    end else begin
      // The payload is zero on cycles with no write.
      beat <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_start) begin
              grant    <= scan_idx;
              rr_ptr   <= (scan_idx == PTR_W'(NUM_LANES-1)) ? '0 : scan_idx + 1'b1;
              blk_size <= in_size;
              beat     <= '{data: in_data, size: in_size, start: 1'b1, last: len_le1,
                            crc: in_crc, filling: in_filling};
              if (len_zero) err_proto <= 1'b1;
              if (len_le1) begin
                count     <= '0;
                blk_count <= blk_count + 16'd1;
              end else begin
                count <= len_sel - 1'b1;
                state <= XFER;
              end
            end else begin
              // A stray body byte with no block open is dropped.
              err_proto <= 1'b1;
            end
          end
        end
        XFER: begin
          if (do_abort) begin
            err_proto <= 1'b1;
            state     <= IDLE;
          end else if (accept) begin
            beat  <= '{data: in_data, size: blk_size, start: 1'b0, last: (count == CNT_W'(1)),
                       crc: in_crc, filling: in_filling};
            count <= count - 1'b1;
            if (count == CNT_W'(1)) begin
              state     <= IDLE;
              blk_count <= blk_count + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lane_data    = beat.data;
  assign lane_size    = beat.size;
  assign lane_start   = beat.start;
  assign lane_last    = beat.last;
  assign lane_crc     = beat.crc;
  assign lane_filling = beat.filling;
endmodule

// File: tb/tb_cb_dispatch.sv
// Random-stream bench for cb_dispatch. A block-level reference model predicts
// the lane writes, aborts, stall, error flag and block count.
module tb_cb_dispatch;
  localparam int N  = 2;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_start, in_size, in_crc, in_filling;
  logic [7:0]    in_data;
  logic          in_stall;
  logic [CW-1:0] cfg_k0_bytes, cfg_k1_bytes;
  logic [N-1:0]  lane_ready;
  logic [N-1:0]  lane_wr, lane_abort;
  logic [7:0]    lane_data;
  logic          lane_size, lane_start, lane_last, lane_crc, lane_filling;
  logic          err_proto;
  logic [15:0]   blk_count;

  cb_dispatch #(.NUM_LANES(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_start(in_start), .in_size(in_size), .in_data(in_data),
    .in_crc(in_crc), .in_filling(in_filling), .in_stall(in_stall),
    .cfg_k0_bytes(cfg_k0_bytes), .cfg_k1_bytes(cfg_k1_bytes),
    .lane_ready(lane_ready), .lane_wr(lane_wr), .lane_data(lane_data),
    .lane_size(lane_size), .lane_start(lane_start), .lane_last(lane_last),
    .lane_crc(lane_crc), .lane_filling(lane_filling), .lane_abort(lane_abort),
    .err_proto(err_proto), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the open block is held as (lane, bytes still to come).
  bit          m_busy;
  int          m_lane, m_left, m_rr, m_blk;
  bit          m_size, m_err;
  logic [N-1:0] e_wr, e_abort;
  logic [12:0] e_pay;
  bit          m_hold;

  function automatic bit m_stall();
    return in_valid && in_start && (m_busy || lane_ready == '0);
  endfunction

  task automatic model_step();
    bit st;
    int len;
    st      = m_stall();
    e_wr    = '0;
    e_abort = '0;
    e_pay   = '0;
    m_hold  = 0;
    if (reset) begin
      m_busy = 0; m_lane = 0; m_left = 0; m_rr = 0; m_blk = 0; m_size = 0; m_err = 0;
    end else if (in_valid) begin
      m_hold = st;
      if (m_busy) begin
        if (in_start) begin
          e_abort = N'(1) << m_lane;
          m_err   = 1;
          m_busy  = 0;
        end else begin
          e_wr  = N'(1) << m_lane;
          e_pay = {in_data, m_size, 1'b0, (m_left == 1), in_crc, in_filling};
          m_left--;
          if (m_left == 0) begin m_busy = 0; m_blk++; end
        end
      end else if (!in_start) begin
        m_err = 1;
      end else if (!st) begin
        for (int k = 0; k < N; k++)
          if (lane_ready[(m_rr + k) % N]) begin m_lane = (m_rr + k) % N; break; end
        m_rr   = (m_lane + 1) % N;
        m_size = in_size;
        len    = in_size ? int'(cfg_k1_bytes) : int'(cfg_k0_bytes);
        if (len == 0) begin m_err = 1; len = 1; end
        e_wr  = N'(1) << m_lane;
        e_pay = {in_data, in_size, 1'b1, (len == 1), in_crc, in_filling};
        if (len == 1) m_blk++;
        else begin m_busy = 1; m_left = len - 1; end
      end
    end
  endtask

  function automatic logic [CW-1:0] pick_len();
    case ($urandom % 8)
      0: return CW'(0);
      1: return CW'(1);
      2: return CW'(2);
      3: return CW'(5);
      4: return CW'(8);
      5: return ($urandom % 6 == 0) ? CW'(768) : CW'(3);
      default: return CW'($urandom_range(1, 20));
    endcase
  endfunction

  int gen_left;
  int len_g;

  initial begin
    reset = 1'b1; in_valid = 0; in_start = 0; in_size = 0; in_data = '0;
    in_crc = 0; in_filling = 0; lane_ready = '1;
    cfg_k0_bytes = CW'(5); cfg_k1_bytes = CW'(8);
    gen_left = 0; m_hold = 0;
    m_busy = 0; m_lane = 0; m_left = 0; m_rr = 0; m_blk = 0; m_size = 0; m_err = 0;
    e_wr = '0; e_abort = '0; e_pay = '0;

    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("lane_wr",    32'(lane_wr),    32'(e_wr));
        chk("lane_abort", 32'(lane_abort), 32'(e_abort));
        chk("payload",    32'({lane_data, lane_size, lane_start, lane_last, lane_crc, lane_filling}),
                          32'(e_pay));
        chk("err_proto",  32'(err_proto),  32'(m_err));
        chk("blk_count",  32'(blk_count),  32'(m_blk[15:0]));
      end

      reset = (cyc < 2) || ($urandom % 500 == 0);
      for (int i = 0; i < N; i++) lane_ready[i] = ($urandom % 100) < 65;
      if (!m_hold) begin
        if ($urandom % 100 < 4) begin
          cfg_k0_bytes = pick_len();
          cfg_k1_bytes = pick_len();
        end
        if ($urandom % 100 < 15) begin
          in_valid = 0;
        end else begin
          in_valid   = 1;
          in_data    = 8'($urandom);
          in_crc     = 1'($urandom);
          in_filling = 1'($urandom);
          in_size    = 1'($urandom);
          in_start   = (gen_left == 0) ? (($urandom % 100) < 94) : (($urandom % 100) < 3);
        end
      end

      #1;
      if (cyc > 0) chk("in_stall", 32'(in_stall), 32'(m_stall()));

      @(posedge clk);
      // Stream generator bookkeeping: what upstream believes it has sent.
      if (reset) gen_left = 0;
      else if (in_valid && !m_stall()) begin
        if (in_start) begin
          len_g    = in_size ? int'(cfg_k1_bytes) : int'(cfg_k0_bytes);
          gen_left = (len_g == 0) ? 0 : len_g - 1;
        end else if (gen_left > 0) gen_left--;
      end
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cb_dispatch.md
Name: cb_dispatch

Overview:
Code-block dispatcher sitting between the segmentation output (byte stream with start/crc/filling/size flags) and NUM_LANES parallel turbo-encoder input buffers. It assigns each complete code block to one free lane, chosen round-robin, and counts bytes to mark the block end. It back-pressures the segmentation output when no lane is free and flags protocol violations.

Parameters:
NUM_LANES, 2, number of encoder lanes (2..4).
CNT_W, 10, width of the byte counter; covers the 768-byte maximum (6144 bits).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  input byte present
in_start  in  1  first byte of a code block
in_size  in  1  block size select: 0 = cfg_k0_bytes, 1 = cfg_k1_bytes
in_data  in  8  payload byte
in_crc  in  1  byte is CRC24 byte
in_filling  in  1  byte is filler
in_stall  out  1  combinational; upstream must hold its byte this cycle
cfg_k0_bytes  in  CNT_W  small block length in bytes, legal 1..768
cfg_k1_bytes  in  CNT_W  large block length in bytes, legal 1..768
lane_ready  in  NUM_LANES  lane i can accept a whole block; sampled only at grant
lane_wr  out  NUM_LANES  one-hot write strobe
lane_data  out  8  byte shared by all lanes
lane_size  out  1  size select of the current block
lane_start  out  1  first byte of block
lane_last  out  1  last byte of block
lane_crc  out  1  forwarded in_crc
lane_filling  out  1  forwarded in_filling
lane_abort  out  NUM_LANES  one-cycle pulse that discards the partial block in that lane
err_proto  out  1  sticky protocol error
blk_count  out  16  completed blocks, wraps at 65535

Behaviour:
- Reset: state IDLE, rr_ptr=0, grant=0, count=0; every output 0.
- Accept = in_valid && !in_stall. Each accepted byte produces a registered lane write one cycle later: lane_wr = one-hot(grant), and data and flags are copied.
- State IDLE:
  - in_stall = in_valid && in_start && (lane_ready == 0).
  - Accepted byte with in_start=1: grant = first ready lane scanning from rr_ptr upward, mod NUM_LANES. Then rr_ptr = grant+1 mod NUM_LANES.
  - len = in_size ? cfg_k1_bytes : cfg_k0_bytes, sampled once. count = len-1. lane_start=1.
  - If len==1: lane_last=1 on the same byte and the state stays IDLE. Otherwise go to XFER.
  - len==0 is illegal: err_proto=1 and the block is treated as len 1.
  - Accepted byte with in_start=0: dropped, no write, err_proto=1.
- State XFER:
  - in_stall = in_valid && in_start.
  - Each accepted byte decrements count.
  - The byte accepted when count==1 gets lane_last=1; state goes to IDLE and blk_count increments on that byte.
  - in_valid && in_start in XFER (premature start):
    - The byte is stalled, not consumed.
    - lane_abort[grant] pulses on the next cycle with no lane_wr; err_proto=1; state goes to IDLE.
    - The held start byte is then granted normally in IDLE.
    - blk_count does not increment for the aborted block.
- in_valid=0 gaps are legal in any state; state and count hold.
- lane_ready changing mid-block has no effect; the granted lane keeps the block until last or abort.
- in_size and the cfg values are ignored except on the start byte.
- Throughput: 1 byte/cycle, no bubbles between back-to-back blocks.
- Reset mid-block: everything returns to its reset value the next cycle. No abort pulse is issued. Downstream lanes are reset by the same signal.
- err_proto is cleared only by reset.

Test Plan:
1. NUM_LANES=2, both ready, cfg_k0=5, cfg_k1=8. Send blocks of size 0,1,0 back-to-back -> lanes 0,1,0; lane_last on bytes 5, 13, 18; blk_count=3; in_stall never high.
2. lane_ready=2'b01 with rr_ptr=1 -> grant lane 0 (wrap scan). Then lane_ready=0 at the next start -> in_stall stays high until lane_ready=2'b10, then grant lane 1 with the byte unchanged.
3. Block len 8: in_valid gaps of 3 cycles after bytes 2 and 6 -> exactly 8 writes, lane_last only on byte 8, and count holds during gaps.
4. Premature in_start after 3 of 8 bytes -> 1 stall cycle, lane_abort[grant] pulse, err_proto=1, next block granted to the next RR lane, blk_count unchanged for the aborted block.
5. Non-start byte in IDLE -> no lane_wr, err_proto=1. cfg_k0=1 block -> a single write with lane_start=lane_last=1, state stays IDLE.
6. Reset asserted at byte 4 of 8 -> all outputs 0 the next cycle, no abort pulse, rr_ptr=0, and the following block goes to lane 0.
